// File: rtl/stall_control_unit.sv
// Pipeline stall/flush controller: load-use, multi-cycle mul/div, memory busy and branch flush.
// Optional STALL_PERF_CNT_EN macro enables the STALL_CYCLES / FLUSH_COUNT performance counters.
module stall_control_unit #(
  parameter int MULDIV_LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        LU_HAZ_SIG,
  input  logic        EX_MULDIV_START,
  input  logic        EX_BRANCH_TAKEN,
  input  logic        DMEM_BUSY,
  output logic        PC_STALL,
  output logic        IF_ID_STALL,
  output logic        ID_EX_STALL,
  output logic        EX_MEM_STALL,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_FLUSH,
  output logic        EX_MEM_FLUSH,
  output logic        MEM_WB_FLUSH,
  output logic [31:0] STALL_CYCLES,
  output logic [15:0] FLUSH_COUNT
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] MULDIV = 1'b1;

  localparam bit         MULTI_CYCLE = (MULDIV_LATENCY > 1);
  // First stall cycle is the RUN cycle that sees the start, so the counter loads LATENCY-2.
  localparam logic [4:0] REM_INIT    = MULTI_CYCLE ? 5'(MULDIV_LATENCY - 2) : 5'd0;

  logic [0:0] state_reg, state_next;
  logic [4:0] rem_reg, rem_next;
  logic       md_stall;

  assign md_stall = ((state_reg == RUN) && EX_MULDIV_START && MULTI_CYCLE) ||
                    ((state_reg == MULDIV) && (rem_reg != 5'd0));

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    if (state_reg == RUN) begin
      if (EX_MULDIV_START && MULTI_CYCLE) begin
        state_next = MULDIV;
        rem_next   = REM_INIT;
      end
    end else begin
      if (rem_reg != 5'd0) begin
        rem_next = rem_reg - 5'd1;
      end else if (!DMEM_BUSY) begin
        state_next = RUN;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= RUN;
      rem_reg   <= 5'd0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
    end
  end

  logic pc_stall_c, if_id_stall_c, id_ex_stall_c, ex_mem_stall_c;
  logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c, mem_wb_flush_c;

  always_comb begin
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    mem_wb_flush_c = 1'b0;
    if (DMEM_BUSY) begin
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
      mem_wb_flush_c = 1'b1;
    end else if (md_stall) begin
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_flush_c = 1'b1;
    end else if (EX_BRANCH_TAKEN) begin
      // Branch squashes the younger instructions, which also resolves any load-use on them.
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
    end else if (LU_HAZ_SIG) begin
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
    end
  end

  // Outputs are forced low for the whole time reset is held.
  assign PC_STALL     = RESET & pc_stall_c;
  assign IF_ID_STALL  = RESET & if_id_stall_c;
  assign ID_EX_STALL  = RESET & id_ex_stall_c;
  assign EX_MEM_STALL = RESET & ex_mem_stall_c;
  assign IF_ID_FLUSH  = RESET & if_id_flush_c;
  assign ID_EX_FLUSH  = RESET & id_ex_flush_c;
  assign EX_MEM_FLUSH = RESET & ex_mem_flush_c;
  assign MEM_WB_FLUSH = RESET & mem_wb_flush_c;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_reg;
  logic [15:0] flush_count_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall_cycles_reg <= 32'd0;
      flush_count_reg  <= 16'd0;
    end else begin
      if (PC_STALL && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
      if (IF_ID_FLUSH && (flush_count_reg != 16'hFFFF)) begin
        flush_count_reg <= flush_count_reg + 16'd1;
      end
    end
  end

  assign STALL_CYCLES = stall_cycles_reg;
  assign FLUSH_COUNT  = flush_count_reg;
`else
  assign STALL_CYCLES = 32'd0;
  assign FLUSH_COUNT  = 16'd0;
`endif

endmodule

// File: tb/tb_stall_control_unit.sv
// Directed bench for stall_control_unit: one instance at latency 4, one at latency 1, same stimulus.
module tb_stall_control_unit;

`ifdef STALL_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  // Output pattern order: {pc_s, ifid_s, idex_s, exmem_s, ifid_f, idex_f, exmem_f, memwb_f}
  localparam logic [7:0] P_IDLE = 8'b0000_0000;
  localparam logic [7:0] P_LU   = 8'b1100_0100;
  localparam logic [7:0] P_MD   = 8'b1110_0010;
  localparam logic [7:0] P_MEM  = 8'b1111_0001;
  localparam logic [7:0] P_BR   = 8'b0000_1100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lu = 1'b0, md = 1'b0, br = 1'b0, dm = 1'b0;

  logic        a_pc, a_ifs, a_ids, a_exs, a_iff, a_idf, a_exf, a_wbf;
  logic        b_pc, b_ifs, b_ids, b_exs, b_iff, b_idf, b_exf, b_wbf;
  logic [31:0] a_sc, b_sc;
  logic [15:0] a_fc, b_fc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  stall_control_unit #(.MULDIV_LATENCY(4)) dut4 (
    .CLK(clk), .RESET(rst_n), .LU_HAZ_SIG(lu), .EX_MULDIV_START(md),
    .EX_BRANCH_TAKEN(br), .DMEM_BUSY(dm),
    .PC_STALL(a_pc), .IF_ID_STALL(a_ifs), .ID_EX_STALL(a_ids), .EX_MEM_STALL(a_exs),
    .IF_ID_FLUSH(a_iff), .ID_EX_FLUSH(a_idf), .EX_MEM_FLUSH(a_exf), .MEM_WB_FLUSH(a_wbf),
    .STALL_CYCLES(a_sc), .FLUSH_COUNT(a_fc)
  );

  stall_control_unit #(.MULDIV_LATENCY(1)) dut1 (
    .CLK(clk), .RESET(rst_n), .LU_HAZ_SIG(lu), .EX_MULDIV_START(md),
    .EX_BRANCH_TAKEN(br), .DMEM_BUSY(dm),
    .PC_STALL(b_pc), .IF_ID_STALL(b_ifs), .ID_EX_STALL(b_ids), .EX_MEM_STALL(b_exs),
    .IF_ID_FLUSH(b_iff), .ID_EX_FLUSH(b_idf), .EX_MEM_FLUSH(b_exf), .MEM_WB_FLUSH(b_wbf),
    .STALL_CYCLES(b_sc), .FLUSH_COUNT(b_fc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, check both patterns mid-cycle, advance past the next edge.
  task automatic cyc(input string tag, input logic l, input logic m, input logic b, input logic d,
                     input logic [7:0] exp4, input logic [7:0] exp1);
    lu = l; md = m; br = b; dm = d;
    @(negedge clk);
    $display("%s: in lu=%0b md=%0b br=%0b dm=%0b lat4=%b lat1=%b", tag, l, m, b, d,
             {a_pc, a_ifs, a_ids, a_exs, a_iff, a_idf, a_exf, a_wbf},
             {b_pc, b_ifs, b_ids, b_exs, b_iff, b_idf, b_exf, b_wbf});
    check({tag, "/lat4"}, 32'({a_pc, a_ifs, a_ids, a_exs, a_iff, a_idf, a_exf, a_wbf}), 32'(exp4));
    check({tag, "/lat1"}, 32'({b_pc, b_ifs, b_ids, b_exs, b_iff, b_idf, b_exf, b_wbf}), 32'(exp1));
    @(posedge clk);
    #1;
  endtask

  task automatic cnt(input string tag, input int s4, input int f4, input int s1, input int f1);
    $display("%s: stall4=%0d flush4=%0d stall1=%0d flush1=%0d", tag, a_sc, a_fc, b_sc, b_fc);
    check({tag, "/stall4"}, a_sc, 32'(PERF * s4));
    check({tag, "/flush4"}, 32'(a_fc), 32'(PERF * f4));
    check({tag, "/stall1"}, b_sc, 32'(PERF * s1));
    check({tag, "/flush1"}, 32'(b_fc), 32'(PERF * f1));
  endtask

  initial begin
    // Reset held 3 cycles; a load-use request must not leak through while in reset.
    rst_n = 1'b0;
    cyc("rst0", 1, 0, 0, 0, P_IDLE, P_IDLE);
    cyc("rst1", 0, 1, 0, 1, P_IDLE, P_IDLE);
    cyc("rst2", 0, 0, 0, 0, P_IDLE, P_IDLE);
    rst_n = 1'b1;
    cyc("idle", 0, 0, 0, 0, P_IDLE, P_IDLE);
    cnt("cnt_reset", 0, 0, 0, 0);

    cyc("lu", 1, 0, 0, 0, P_LU, P_LU);
    cyc("lu_after", 0, 0, 0, 0, P_IDLE, P_IDLE);
    cnt("cnt_lu", 1, 0, 1, 0);

    // Mul/div: three stall cycles at latency 4, none at latency 1.
    cyc("md_c1", 0, 1, 0, 0, P_MD, P_IDLE);
    cyc("md_c2", 0, 1, 0, 0, P_MD, P_IDLE);
    cyc("md_c3", 0, 1, 0, 0, P_MD, P_IDLE);
    cyc("md_c4", 0, 1, 0, 0, P_IDLE, P_IDLE);
    cyc("md_after", 0, 0, 0, 0, P_IDLE, P_IDLE);
    cnt("cnt_md", 4, 0, 1, 0);

    // Memory busy overlapping the first two mul/div cycles.
    cyc("mdm_c1", 0, 1, 0, 1, P_MEM, P_MEM);
    cyc("mdm_c2", 0, 1, 0, 1, P_MEM, P_MEM);
    cyc("mdm_c3", 0, 1, 0, 0, P_MD, P_IDLE);
    cyc("mdm_c4", 0, 1, 0, 0, P_IDLE, P_IDLE);
    cyc("mdm_after", 0, 0, 0, 0, P_IDLE, P_IDLE);
    cnt("cnt_mdm", 7, 0, 3, 0);

    cyc("br_lu", 1, 0, 1, 0, P_BR, P_BR);
    cnt("cnt_br_lu", 7, 1, 3, 1);

    // Branch held through a memory stall is only taken once memory frees up.
    cyc("br_dm1", 0, 0, 1, 1, P_MEM, P_MEM);
    cyc("br_dm2", 0, 0, 1, 1, P_MEM, P_MEM);
    cyc("br_dm3", 0, 0, 1, 0, P_BR, P_BR);
    cyc("br_dm_after", 0, 0, 0, 0, P_IDLE, P_IDLE);
    cnt("cnt_br_dm", 9, 2, 5, 2);

    // Reset while in MULDIV with REM=2.
    cyc("rmd_c1", 0, 1, 0, 0, P_MD, P_IDLE);
    rst_n = 1'b0;
    cyc("rmd_rst", 0, 1, 0, 0, P_IDLE, P_IDLE);
    cnt("cnt_rmd_rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc("rmd_rel1", 0, 0, 0, 0, P_IDLE, P_IDLE);
    cyc("rmd_rel2", 1, 0, 0, 0, P_LU, P_LU);
    cnt("cnt_rmd", 1, 0, 1, 0);

    // Branch arriving with a mul/div is deferred until EX advances.
    cyc("mdbr_c1", 0, 1, 1, 0, P_MD, P_BR);
    cyc("mdbr_c2", 0, 1, 1, 0, P_MD, P_BR);
    cyc("mdbr_c3", 0, 1, 1, 0, P_MD, P_BR);
    cyc("mdbr_c4", 0, 1, 1, 0, P_BR, P_BR);
    cyc("mdbr_after", 0, 0, 0, 0, P_IDLE, P_IDLE);
    cnt("cnt_mdbr", 4, 1, 1, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
